// File: rtl/wb_data_ram_if.sv
// Wishbone B4 pipelined data-port bundle between the core (master) and the data RAM (slave).
interface wb_data_ram_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_addr;
    logic [31:0] wb_wr_data;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_stall;
    logic [31:0] wb_rd_data;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_wr_data, wb_sel,
        input  wb_ack, wb_stall, wb_rd_data
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wr_data, wb_sel,
        output wb_ack, wb_stall, wb_rd_data
    );
endinterface

// File: rtl/wb_data_ram.sv
// Wishbone B4 pipelined data RAM: byte-strobed writes, fixed-latency in-order responses.
// Define WB_DATA_RAM_STALL_INJECT_EN to add LFSR-driven random stalls on top of the outstanding limit.
module wb_data_ram #(
    parameter int          MEM_DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          READ_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    wb_data_ram_if.slave  wb
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]      mem [MEM_DEPTH];
    logic [31:0]      offset;
    logic [IDX_W-1:0] index;
    logic             accept;
    logic             ack;
    logic             limitStall;

    logic             pipeValid_q [READ_LATENCY];
    logic             pipeValid_d [READ_LATENCY];
    logic             pipeWe_q    [READ_LATENCY];
    logic             pipeWe_d    [READ_LATENCY];
    logic [31:0]      pipeData_q  [READ_LATENCY];
    logic [31:0]      pipeData_d  [READ_LATENCY];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign offset     = wb.wb_addr - BASE_ADDR;
    assign index      = IDX_W'(offset >> 2);
    assign limitStall = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign accept     = wb.wb_cyc & wb.wb_stb & ~wb.wb_stall & ~rst;

`ifdef WB_DATA_RAM_STALL_INJECT_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign wb.wb_stall = limitStall | (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= STALL_SEED;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign wb.wb_stall = limitStall;
`endif

    // The RAM is never reset; only accepted writes touch it, byte lane by byte lane.
    always_ff @(posedge clk) begin
        if (accept && wb.wb_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.wb_sel[b]) mem[index][8*b +: 8] <= wb.wb_wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        pipeValid_d[0] = accept;
        pipeWe_d[0]    = wb.wb_we;
        pipeData_d[0]  = (accept && !wb.wb_we) ? mem[index] : 32'h0;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipeValid_d[k] = pipeValid_q[k-1];
            pipeWe_d[k]    = pipeWe_q[k-1];
            pipeData_d[k]  = pipeData_q[k-1];
        end
        if (!wb.wb_cyc) begin
            for (int k = 0; k < READ_LATENCY; k++) pipeValid_d[k] = 1'b0;
        end
    end

    assign ack           = pipeValid_q[READ_LATENCY-1] & wb.wb_cyc;
    assign wb.wb_ack     = ack;
    assign wb.wb_rd_data = (ack && !pipeWe_q[READ_LATENCY-1]) ? pipeData_q[READ_LATENCY-1] : 32'h0;

    always_comb begin
        count_d = count_q;
        if (!wb.wb_cyc)          count_d = '0;
        else if (accept && !ack) count_d = count_q + CNT_W'(1);
        else if (!accept && ack) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipeValid_q[k] <= 1'b0;
                pipeWe_q[k]    <= 1'b0;
                pipeData_q[k]  <= 32'h0;
            end
        end else begin
            count_q <= count_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipeValid_q[k] <= pipeValid_d[k];
                pipeWe_q[k]    <= pipeWe_d[k];
                pipeData_q[k]  <= pipeData_d[k];
            end
        end
    end
endmodule
